hub_port: RTL and testbench
===========================

Name: hub_port

Overview:
- Hub-bus initiator that occupies one cog slot, either an absent-cog slot or a dedicated port slot.
- Lets a non-cog agent (loader, debug bridge, DMA) issue hub reads, writes and hub ops using the same slot protocol the cogs use.
- Sits beside the cogs in the top level.
- Its bus outputs are OR-merged into the hub request bus with the cogs', and it consumes the shared `bus_q`/`bus_c` and its own `bus_ack` bit.

Parameters:
- `TIMEOUT`, default 8: slot visits to wait for `bus_ack` before aborting. 0 disables the timeout.
- `ALIGN`, default 1: when 1, force address low bits to 0 per access size. When 0, pass the address unmodified.

Ports:
- `clk_cog`  in  1  cog clock; all state on posedge.
- `nres`  in  1  reset, asynchronous, active-low.
- `ena_bus`  in  1  hub phase enable; high every other clk_cog.
- `bus_sel`  in  1  this port's slot select from the hub rotation.
- `bus_ack`  in  1  hub acknowledge for this slot.
- `bus_q`  in  32  hub read data.
- `bus_c`  in  1  hub returned flag (lock/cog-op carry).
- `bus_r`  out  1  request active.
- `bus_e`  out  1  hub-op request.
- `bus_w`  out  1  write request.
- `bus_s`  out  2  size: 00 byte, 01 word, 10 long, 11 reserved (treated as long).
- `bus_a`  out  16  byte address.
- `bus_d`  out  32  write data / hub-op operand.
- `req_valid`  in  1  agent request valid.
- `req_ready`  out  1  port can accept a request.
- `req_kind`  in  2  00 read, 01 write, 10 hub op, 11 reserved (treated as read).
- `req_size`  in  2  as `bus_s`.
- `req_addr`  in  16  byte address.
- `req_data`  in  32  write data / operand.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  agent accepts response.
- `rsp_data`  out  32  captured `bus_q` (0 for writes).
- `rsp_c`  out  1  captured `bus_c`.
- `rsp_err`  out  1  timeout abort.

Behaviour:
- Reset is asynchronous on `nres` low. All registers clear, state is IDLE, `req_ready`=0, and every output is 0, including all bus outputs.
- `req_ready` rises on the first clock after `nres` deasserts.
- Bus outputs are the registered request ANDed with `bus_sel`. They must be exactly 0 whenever `bus_sel`=0, because the top level OR-merges them.
- States:
  - IDLE: `req_ready`=1. A `req_valid&req_ready` edge latches kind, size, address (aligned if `ALIGN`: byte none, word a[0]=0, long a[1:0]=0) and data; go to ARMED.
  - ARMED: registered request is present. When `bus_sel` is sampled high, go to ISSUE.
    - `bus_r`=1 for all kinds.
    - `bus_w`=1 only for write.
    - `bus_e`=1 only for hub op.
  - ISSUE: outputs stay valid for every clock `bus_sel`=1.
    - On a posedge with `bus_sel&bus_ack`: capture `bus_q` (0 for writes) and `bus_c`; go to RESP.
    - On a posedge with `bus_sel&ena_bus&!bus_ack`: the slot closes unanswered; increment the wait counter; stay in ISSUE. Outputs are re-presented automatically at the next slot.
    - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`: set `rsp_err`=1, `rsp_data`=0, `rsp_c`=0; go to RESP.
  - RESP: `rsp_valid`=1 with stable data. On `rsp_valid&rsp_ready`, clear the counter and go to IDLE.
- Exactly one outstanding request at a time; `req_ready`=0 outside IDLE.
- Request-to-response latency: at least 1 clock after the `bus_ack` posedge. `rsp_valid` rises the clock after the ack is sampled.
- Simultaneous `bus_ack` and timeout: ack wins and `rsp_err`=0.
- `bus_ack` while `bus_sel`=0 is ignored.
- `bus_sel` high in IDLE or RESP: port drives 0s.
- Wait counter: `$clog2(TIMEOUT+1)` bits, saturating. Counts only slot closures (`bus_sel&ena_bus`).
- Reset mid-operation: request is dropped without completion and no response is produced. The agent must reissue.

Decomposition:
- Shared package `hub_pkg`:
  - size encodings `SZ_BYTE`/`SZ_WORD`/`SZ_LONG`
  - kind encodings `K_RD`/`K_WR`/`K_OP`
  - state enum `hp_state_t`
  - widths `HUB_AW`=16, `HUB_DW`=32
  - function `hub_align(addr,size)`
- No sub-module: FSM, request register and counter live in one module. Alignment is the package function.

Test Plan:
- Long read at 0x1237, hub acks on the first slot with `bus_q`=0xDEADBEEF, `bus_c`=1:
  - `bus_a`=0x1234, `bus_s`=10, `bus_r`=1, `bus_w`=0 only while `bus_sel`=1.
  - `rsp_data`=0xDEADBEEF, `rsp_c`=1, `rsp_err`=0.
- Byte write 0xA5 at 0x0101, hub withholds ack for 2 slots then acks:
  - outputs re-presented in 3 consecutive slots and zero between them.
  - `rsp_valid` with `rsp_data`=0.
- `TIMEOUT`=3, hub never acks: `rsp_err`=1 after the 3rd slot closure; `bus_r` 0 afterwards.
- Back-pressure: `rsp_ready` held 0 for 10 clocks; `rsp_valid` and data stable; `req_ready`=0 throughout; a new request is accepted one clock after the handshake.
- Assert `nres`=0 in ISSUE with `bus_sel`=1: all bus outputs 0 in the same cycle; no `rsp_valid` after release; `req_ready`=1 on the first clock after `nres`=1.
- `ALIGN`=0, word read at 0x0003: `bus_a`=0x0003. `bus_ack` pulsed while `bus_sel`=0: ignored, state unchanged.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared hub-bus definitions: access sizes, request kinds, port FSM states
// and the address alignment helper.
package hub_pkg;

    localparam int HUB_AW = 16;
    localparam int HUB_DW = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    localparam logic [1:0] K_RD = 2'b00;
    localparam logic [1:0] K_WR = 2'b01;
    localparam logic [1:0] K_OP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ISSUE,
        ST_RESP
    } hp_state_t;

    // Clear the address bits below the access size; reserved size acts as long.
    function automatic logic [HUB_AW-1:0] hub_align(input logic [HUB_AW-1:0] addr,
                                                    input logic [1:0]        size);
        logic [HUB_AW-1:0] res;
        case (size)
            SZ_BYTE: res = addr;
            SZ_WORD: res = {addr[HUB_AW-1:1], 1'b0};
            default: res = {addr[HUB_AW-1:2], 2'b00};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hub_port.sv
// Hub-bus initiator occupying one cog slot on behalf of a non-cog agent.
// Single outstanding request; bus outputs are zero whenever the slot is not selected.
module hub_port
    import hub_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter bit ALIGN   = 1'b1
) (
    input  logic              clk_cog,
    input  logic              nres,
    input  logic              ena_bus,
    input  logic              bus_sel,
    input  logic              bus_ack,
    input  logic [HUB_DW-1:0] bus_q,
    input  logic              bus_c,
    output logic              bus_r,
    output logic              bus_e,
    output logic              bus_w,
    output logic [1:0]        bus_s,
    output logic [HUB_AW-1:0] bus_a,
    output logic [HUB_DW-1:0] bus_d,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [1:0]        req_size,
    input  logic [HUB_AW-1:0] req_addr,
    input  logic [HUB_DW-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [HUB_DW-1:0] rsp_data,
    output logic              rsp_c,
    output logic              rsp_err
);

    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    hp_state_t         state_q, state_d;
    logic              live_q;
    logic [1:0]        kind_q;
    logic [1:0]        size_q;
    logic [HUB_AW-1:0] addr_q;
    logic [HUB_DW-1:0] data_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [HUB_DW-1:0] rsp_data_q;
    logic              rsp_c_q;
    logic              rsp_err_q;

    logic              load_req;
    logic              cap_ack;
    logic              cap_to;
    logic              drive;
    logic [1:0]        kind_n;
    logic [1:0]        size_n;

    assign kind_n = (req_kind == K_WR || req_kind == K_OP) ? req_kind : K_RD;
    assign size_n = (req_size == 2'b11) ? SZ_LONG : req_size;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_req = 1'b0;
        cap_ack  = 1'b0;
        cap_to   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    load_req = 1'b1;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED, ST_ISSUE: begin
                // Only a selected slot can answer or close; ack outside the slot is noise.
                if (bus_sel) begin
                    state_d = ST_ISSUE;
                    if (bus_ack) begin
                        cap_ack = 1'b1;
                        state_d = ST_RESP;
                    end else if (ena_bus) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                        if (TIMEOUT != 0 && cnt_d == TO_VAL) begin
                            cap_to  = 1'b1;
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q    <= ST_IDLE;
            live_q     <= 1'b0;
            kind_q     <= K_RD;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_c_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            cnt_q   <= cnt_d;
            if (load_req) begin
                kind_q <= kind_n;
                size_q <= size_n;
                addr_q <= ALIGN ? hub_align(req_addr, size_n) : req_addr;
                data_q <= req_data;
            end
            if (cap_ack) begin
                rsp_data_q <= (kind_q == K_WR) ? '0 : bus_q;
                rsp_c_q    <= bus_c;
                rsp_err_q  <= 1'b0;
            end else if (cap_to) begin
                rsp_data_q <= '0;
                rsp_c_q    <= 1'b0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    // The top level OR-merges these with the cogs, so they must be 0 off-slot.
    assign drive = bus_sel && (state_q == ST_ARMED || state_q == ST_ISSUE);
    assign bus_r = drive;
    assign bus_w = drive && (kind_q == K_WR);
    assign bus_e = drive && (kind_q == K_OP);
    assign bus_s = drive ? size_q : 2'b00;
    assign bus_a = drive ? addr_q : '0;
    assign bus_d = drive ? data_q : '0;

    assign req_ready = live_q && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_hub_port.sv
// Directed bench for hub_port: slot protocol, timeout, back-pressure, reset and alignment.
module tb_hub_port;
    import hub_pkg::*;

    logic        clk_cog = 1'b0;
    logic        nres;
    logic        ena_bus, bus_sel, bus_ack, bus_c;
    logic [31:0] bus_q;
    logic        req_valid, rsp_ready;
    logic [1:0]  req_kind, req_size;
    logic [15:0] req_addr;
    logic [31:0] req_data;

    logic        bus_r, bus_e, bus_w, req_ready, rsp_valid, rsp_c, rsp_err;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d, rsp_data;

    logic        bus_r2, bus_e2, bus_w2, req_ready2, rsp_valid2, rsp_c2, rsp_err2;
    logic [1:0]  bus_s2;
    logic [15:0] bus_a2;
    logic [31:0] bus_d2, rsp_data2;

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        e;
    } rsp_t;
    rsp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_cog = ~clk_cog;

    hub_port #(.TIMEOUT(3), .ALIGN(1'b1)) dut (
        .clk_cog(clk_cog), .nres(nres), .ena_bus(ena_bus), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_q(bus_q), .bus_c(bus_c),
        .bus_r(bus_r), .bus_e(bus_e), .bus_w(bus_w), .bus_s(bus_s), .bus_a(bus_a), .bus_d(bus_d),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_size(req_size),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_c(rsp_c),
        .rsp_err(rsp_err)
    );

    hub_port #(.TIMEOUT(8), .ALIGN(1'b0)) dut2 (
        .clk_cog(clk_cog), .nres(nres), .ena_bus(ena_bus), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_q(bus_q), .bus_c(bus_c),
        .bus_r(bus_r2), .bus_e(bus_e2), .bus_w(bus_w2), .bus_s(bus_s2), .bus_a(bus_a2), .bus_d(bus_d2),
        .req_valid(req_valid), .req_ready(req_ready2), .req_kind(req_kind), .req_size(req_size),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_c(rsp_c2),
        .rsp_err(rsp_err2)
    );

    function automatic logic [63:0] pk(input logic r, input logic e, input logic w,
                                       input logic [1:0] s, input logic [15:0] a,
                                       input logic [31:0] d);
        return {11'd0, r, e, w, s, a, d};
    endfunction

    function automatic logic [63:0] ob();
        return {11'd0, bus_r, bus_e, bus_w, bus_s, bus_a, bus_d};
    endfunction

    function automatic logic [63:0] ob2();
        return {11'd0, bus_r2, bus_e2, bus_w2, bus_s2, bus_a2, bus_d2};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_cog);
        #1;
    endtask

    // One two-clock slot (closing on the second clock) followed by one unselected clock.
    task automatic slot(input string tag, input logic [63:0] expv, input logic ack,
                        input logic [31:0] q, input logic c, input logic exp_rv);
        bus_sel = 1'b1; ena_bus = 1'b0; bus_ack = 1'b0;
        #1 chk({tag, "_bus_a"}, ob(), expv);
        step();
        bus_sel = 1'b1; ena_bus = 1'b1; bus_ack = ack; bus_q = q; bus_c = c;
        #1 chk({tag, "_bus_b"}, ob(), expv);
        chk({tag, "_rv_early"}, 64'(rsp_valid), 64'd0);
        step();
        bus_sel = 1'b0; bus_ack = 1'b0; bus_q = 32'h0; bus_c = 1'b0;
        #1 chk({tag, "_gap"}, ob(), 64'd0);
        chk({tag, "_rv"}, 64'(rsp_valid), 64'(exp_rv));
        step();
        ena_bus = 1'b0;
    endtask

    task automatic collect(input string tag);
        rsp_t e;
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        if (!rsp_valid) begin
            chk({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(e.d));
            chk({tag, "_rsp_c"}, 64'(rsp_c), 64'(e.c));
            chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(e.e));
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            #1 chk({tag, "_rv_drop"}, 64'(rsp_valid), 64'd0);
            chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
        end
    endtask

    task automatic issue(input logic [1:0] k, input logic [1:0] s,
                         input logic [15:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_kind = k; req_size = s; req_addr = a; req_data = d;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        nres = 1'b0; ena_bus = 1'b0; bus_sel = 1'b1; bus_ack = 1'b0; bus_q = '0; bus_c = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0; req_kind = K_RD; req_size = SZ_BYTE;
        req_addr = '0; req_data = '0;
        repeat (3) step();
        #1 chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rv", 64'(rsp_valid), 64'd0);
        chk("rst_bus", ob(), 64'd0);
        chk("rst_rsp", {31'd0, rsp_data, rsp_c, rsp_err}, 64'd0);
        nres = 1'b1; bus_sel = 1'b0;
        #1 chk("rel_ready_lo", 64'(req_ready), 64'd0);
        step();
        chk("rel_ready_hi", 64'(req_ready), 64'd1);

        // Long read, acked in the first slot
        issue(K_RD, SZ_LONG, 16'h1237, 32'h0);
        sb.push_back('{d: 32'hDEADBEEF, c: 1'b1, e: 1'b0});
        #1 chk("t1_busy", 64'(req_ready), 64'd0);
        chk("t1_offslot", ob(), 64'd0);
        slot("t1", pk(1, 0, 0, SZ_LONG, 16'h1234, 32'h0), 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        collect("t1");

        // Byte write, ack withheld for two slots
        issue(K_WR, SZ_BYTE, 16'h0101, 32'h000000A5);
        sb.push_back('{d: 32'h0, c: 1'b0, e: 1'b0});
        slot("t2s1", pk(1, 0, 1, SZ_BYTE, 16'h0101, 32'hA5), 1'b0, 32'h0, 1'b0, 1'b0);
        slot("t2s2", pk(1, 0, 1, SZ_BYTE, 16'h0101, 32'hA5), 1'b0, 32'h0, 1'b0, 1'b0);
        slot("t2s3", pk(1, 0, 1, SZ_BYTE, 16'h0101, 32'hA5), 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
        collect("t2");

        // Hub op with response back-pressure, next request waiting
        issue(K_OP, SZ_LONG, 16'h2002, 32'h12345678);
        sb.push_back('{d: 32'hCAFEF00D, c: 1'b1, e: 1'b0});
        slot("t4", pk(1, 1, 0, SZ_LONG, 16'h2000, 32'h12345678), 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
        req_valid = 1'b1; req_kind = K_RD; req_size = SZ_LONG; req_addr = 16'h0040; req_data = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1 chk("t4_hold_rv", 64'(rsp_valid), 64'd1);
            chk("t4_hold_data", {31'd0, rsp_data, rsp_c, rsp_err}, {31'd0, 32'hCAFEF00D, 1'b1, 1'b0});
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
            step();
        end
        collect("t4");
        step();
        req_valid = 1'b0;
        sb.push_back('{d: 32'h0, c: 1'b0, e: 1'b1});
        #1 chk("t4_next_taken", 64'(req_ready), 64'd0);

        // Timeout after the third unanswered slot
        slot("t3s1", pk(1, 0, 0, SZ_LONG, 16'h0040, 32'h0), 1'b0, 32'h55555555, 1'b1, 1'b0);
        slot("t3s2", pk(1, 0, 0, SZ_LONG, 16'h0040, 32'h0), 1'b0, 32'h55555555, 1'b1, 1'b0);
        slot("t3s3", pk(1, 0, 0, SZ_LONG, 16'h0040, 32'h0), 1'b0, 32'h55555555, 1'b1, 1'b1);
        bus_sel = 1'b1;
        #1 chk("t3_bus_after", ob(), 64'd0);
        bus_sel = 1'b0;
        collect("t3");

        // Reset while issuing
        issue(K_WR, SZ_LONG, 16'h0300, 32'h1);
        bus_sel = 1'b1;
        #1 chk("t5_issue_bus", ob(), pk(1, 0, 1, SZ_LONG, 16'h0300, 32'h1));
        step();
        nres = 1'b0;
        #1 chk("t5_rst_bus", ob(), 64'd0);
        chk("t5_rst_ready", 64'(req_ready), 64'd0);
        repeat (2) step();
        nres = 1'b1; bus_sel = 1'b0;
        #1 chk("t5_rel_ready_lo", 64'(req_ready), 64'd0);
        step();
        chk("t5_rel_ready_hi", 64'(req_ready), 64'd1);
        bus_sel = 1'b1; ena_bus = 1'b1; bus_ack = 1'b1; bus_q = 32'h77777777;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_idle_bus", ob(), 64'd0);
            chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        bus_sel = 1'b0; ena_bus = 1'b0; bus_ack = 1'b0; bus_q = 32'h0;
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Unaligned word read; dut2 passes the address untouched
        issue(K_RD, SZ_WORD, 16'h0003, 32'h0);
        sb.push_back('{d: 32'h0BADCAFE, c: 1'b0, e: 1'b0});
        ena_bus = 1'b1; bus_ack = 1'b1; bus_q = 32'h11111111;
        step();
        ena_bus = 1'b0; bus_ack = 1'b0; bus_q = 32'h0;
        #1 chk("t6_stray_ack_rv", 64'(rsp_valid), 64'd0);
        chk("t6_stray_ack_bus", ob(), 64'd0);
        bus_sel = 1'b1;
        #1 chk("t6_aligned", ob(), pk(1, 0, 0, SZ_WORD, 16'h0002, 32'h0));
        chk("t6_unaligned", ob2(), pk(1, 0, 0, SZ_WORD, 16'h0003, 32'h0));
        step();
        ena_bus = 1'b1; bus_ack = 1'b1; bus_q = 32'h0BADCAFE; bus_c = 1'b0;
        step();
        bus_sel = 1'b0; ena_bus = 1'b0; bus_ack = 1'b0; bus_q = 32'h0;
        #1 chk("t6_dut2_rv", 64'(rsp_valid2), 64'd1);
        chk("t6_dut2_data", 64'(rsp_data2), 64'h0BADCAFE);
        collect("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
